onehot_strobe_gen: RTL



---
 rtl/onehot_strobe_gen_pkg.sv | 25 ++
 rtl/onehot_strobe_gen_strobe_timer.sv | 38 +++
 rtl/onehot_strobe_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/onehot_strobe_gen_pkg.sv
// Shared types and helpers for the one-hot strobe generator.
package onehot_strobe_gen_pkg;

  localparam int DEF_IDX_W = 2;
  localparam int DEF_OH_W  = 1 << DEF_IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Index to one-hot select word at the default bus width.
  function automatic logic [DEF_OH_W-1:0] onehot_of(input logic [DEF_IDX_W-1:0] idx);
    return DEF_OH_W'(1) << idx;
  endfunction

  // Timer width wide enough to hold the larger of the two load values.
  function automatic int timer_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/onehot_strobe_gen_strobe_timer.sv
// Loadable down-counter with a zero flag; shared by the DRIVE and GAP phases.
module onehot_strobe_gen_strobe_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down while enabled, saturating at zero.
  always_comb begin
    // NOTE: cnt_d gets a default before any condition so every path assigns it and no latch is inferred.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/onehot_strobe_gen.sv
// Accepts a channel index over valid/ready, drives a registered one-hot strobe
// for HOLD_CYCLES cycles, then enforces a GAP_CYCLES idle gap before the next
// request. Completion is flagged by done, cancellation by aborted.
module onehot_strobe_gen
  import onehot_strobe_gen_pkg::*;
#(
  parameter int IDX_W       = DEF_IDX_W,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [IDX_W-1:0]      in_idx,
  output logic                  in_ready,
  input  logic                  abort,
  output logic [(1<<IDX_W)-1:0] onehot,
  output logic                  active,
  output logic                  done,
  output logic                  aborted
);

  localparam int OH_W  = 1 << IDX_W;
  localparam int CNT_W = timer_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic             HAS_GAP   = (GAP_CYCLES > 0);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("onehot_strobe_gen: HOLD_CYCLES must be at least 1");
  end
  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("onehot_strobe_gen: GAP_CYCLES must not be negative");
  end

  state_e          state_q, state_d;
  logic [OH_W-1:0] onehot_q, onehot_d;
  logic            done_q, done_d;
  logic            aborted_q, aborted_d;
  logic [OH_W-1:0] req_onehot;
  logic            tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  // The package decoder covers the default bus; other widths use a plain shift.
  if (IDX_W == DEF_IDX_W) begin : g_pkg_dec
    assign req_onehot = onehot_of(in_idx);
  end else begin : g_shift_dec
    assign req_onehot = OH_W'(1) << in_idx;
  end

  onehot_strobe_gen_strobe_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  assign in_ready = (state_q == IDLE);

  // Next-state, strobe and pulse decisions; abort beats normal completion.
  always_comb begin
    state_d   = state_q;
    onehot_d  = onehot_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d  = DRIVE;
          onehot_d = req_onehot;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
        end
      end
      DRIVE: begin
        if (abort || tmr_zero) begin
          onehot_d  = '0;
          aborted_d = abort;
          done_d    = !abort;
          if (HAS_GAP) begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          state_d = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
      end
    endcase
  end

  // State, strobe and pulse registers; reset leaves no pending pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      onehot_q  <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      onehot_q  <= onehot_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign onehot  = onehot_q;
  assign active  = |onehot_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule
